cache_sim_core: RTL and testbench

// - Set-associative cache tag/state model with built-in address parsing and statistics counters.
// - Consumes one trace command per accepted cycle (command code + 32-bit address).
// - Splits the address into tag/index/offset, performs lookup and LRU replacement,
//   and maintains read/write/hit/miss counters.
// - Sits under the trace-file front end, which streams commands into it.

---
 rtl/cache_sim_core.sv | 197 +++++++++++++++++++
 tb/tb_cache_sim_core.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_sim_core.sv
// Four-way set-associative cache tag/state model with address split, LRU replacement
// and statistics counters. Define CACHE_SIM_DEBUG_EN for per-command simulation trace output.
module cache_sim_core #(
  parameter int OFFSET_BITS = 6,
  parameter int INDEX_BITS  = 8,
  parameter int TAG_BITS    = 18,
  parameter int WAYS        = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  input  logic [3:0]             cmd,
  input  logic [31:0]            read_address,
  output logic [TAG_BITS-1:0]    tag,
  output logic [INDEX_BITS-1:0]  index,
  output logic [OFFSET_BITS-1:0] byte_select,
  output logic                   cmd_done,
  output logic                   hit_flag,
  output logic [31:0]            cache_read,
  output logic [31:0]            cache_write,
  output logic [31:0]            cache_hit,
  output logic [31:0]            cache_miss
);

  localparam int SETS = 1 << INDEX_BITS;

  generate
    if (OFFSET_BITS + INDEX_BITS + TAG_BITS != 32) begin : g_bad_split
      $error("cache_sim_core: OFFSET_BITS+INDEX_BITS+TAG_BITS must equal 32");
    end
    if (WAYS != 4) begin : g_bad_ways
      $error("cache_sim_core: WAYS must be 4 (2-bit LRU ages)");
    end
  endgenerate

  typedef enum logic [3:0] {
    CMD_READ   = 4'd0,
    CMD_WRITE  = 4'd1,
    CMD_IFETCH = 4'd2,
    CMD_INVAL  = 4'd3,
    CMD_CLEAR  = 4'd8,
    CMD_PRINT  = 4'd9
  } cmd_e;

  logic [WAYS-1:0]                valid_q [SETS];
  logic [WAYS-1:0][1:0]           age_q   [SETS];
  logic [WAYS-1:0][TAG_BITS-1:0]  tag_q   [SETS];

  logic        cmd_done_q, cmd_done_d;
  logic        hit_flag_q, hit_flag_d;
  logic [31:0] read_cnt_q, read_cnt_d;
  logic [31:0] write_cnt_q, write_cnt_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  logic                      do_access, do_inval, do_clear, do_print;
  logic [WAYS-1:0]           set_valid, set_valid_d, match;
  logic [WAYS-1:0][1:0]      set_age, set_age_d;
  logic [WAYS-1:0][TAG_BITS-1:0] set_tag;
  logic                      hit, found_inv, set_write;
  logic [1:0]                hit_way, victim, touch_way;

  assign tag         = read_address[31 -: TAG_BITS];
  assign index       = read_address[OFFSET_BITS +: INDEX_BITS];
  assign byte_select = read_address[OFFSET_BITS-1:0];

  assign set_valid = valid_q[index];
  assign set_age   = age_q[index];
  assign set_tag   = tag_q[index];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    do_access = cmd_valid && (cmd == CMD_READ || cmd == CMD_WRITE || cmd == CMD_IFETCH);
    do_inval  = cmd_valid && (cmd == CMD_INVAL);
    do_clear  = cmd_valid && (cmd == CMD_CLEAR);
    do_print  = cmd_valid && (cmd == CMD_PRINT);

    match   = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      match[w] = set_valid[w] && (set_tag[w] == tag);
      if (match[w]) hit_way = 2'(w);
    end
    hit = |match;

    // Victim: lowest-numbered invalid way, otherwise the least recently used (age 3).
    victim    = '0;
    found_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!set_valid[w]) begin
        victim    = 2'(w);
        found_inv = 1'b1;
      end
    end
    if (!found_inv) begin
      for (int w = 0; w < WAYS; w++) begin
        if (set_age[w] == 2'd3) victim = 2'(w);
      end
    end
    touch_way = hit ? hit_way : victim;
  end

  always_comb begin
    set_valid_d = set_valid;
    set_age_d   = set_age;
    set_write   = 1'b0;
    cmd_done_d  = do_access || do_inval || do_clear || do_print;
    hit_flag_d  = hit_flag_q;
    read_cnt_d  = read_cnt_q;
    write_cnt_d = write_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;

    if (do_clear) begin
      hit_flag_d  = 1'b0;
      read_cnt_d  = '0;
      write_cnt_d = '0;
      hit_cnt_d   = '0;
      miss_cnt_d  = '0;
    end else if (do_access) begin
      set_write  = 1'b1;
      hit_flag_d = hit;
      if (cmd == CMD_WRITE) write_cnt_d = write_cnt_q + 32'd1;
      else                  read_cnt_d  = read_cnt_q + 32'd1;
      if (hit) hit_cnt_d  = hit_cnt_q + 32'd1;
      else     miss_cnt_d = miss_cnt_q + 32'd1;
      set_valid_d[touch_way] = 1'b1;
      // Ages younger than the touched way shift up by one, keeping a 0..3 permutation.
      for (int w = 0; w < WAYS; w++) begin
        if (set_age[w] < set_age[touch_way]) set_age_d[w] = set_age[w] + 2'd1;
      end
      set_age_d[touch_way] = 2'd0;
    end else if (do_inval) begin
      set_write  = 1'b1;
      hit_flag_d = hit;
      if (hit) set_valid_d[hit_way] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= 2'(w);
      end
      cmd_done_q  <= 1'b0;
      hit_flag_q  <= 1'b0;
      read_cnt_q  <= '0;
      write_cnt_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      cmd_done_q  <= cmd_done_d;
      hit_flag_q  <= hit_flag_d;
      read_cnt_q  <= read_cnt_d;
      write_cnt_q <= write_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      if (do_clear) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[s] <= '0;
          for (int w = 0; w < WAYS; w++) age_q[s][w] <= 2'(w);
        end
      end else if (set_write) begin
        valid_q[index] <= set_valid_d;
        age_q[index]   <= set_age_d;
      end
    end
  end

  // NOTE: the tag array has no reset; a tag is only ever looked at behind its valid bit.
  always_ff @(posedge clk) begin
    if (do_access && !hit) tag_q[index][victim] <= tag;
  end

  assign cmd_done    = cmd_done_q;
  assign hit_flag    = hit_flag_q;
  assign cache_read  = read_cnt_q;
  assign cache_write = write_cnt_q;
  assign cache_hit   = hit_cnt_q;
  assign cache_miss  = miss_cnt_q;

`ifdef CACHE_SIM_DEBUG_EN
  always_ff @(posedge clk) begin
    if (rst_n && cmd_done_d) begin
      $display("cache_sim_core: cmd=%0d addr=0x%08h tag=0x%0h index=0x%0h %s",
               cmd, read_address, tag, index,
               (do_access || do_inval) ? (hit ? "HIT" : "MISS") : "-");
      if (do_print)
        $display("cache_sim_core: reads=%0d writes=%0d hits=%0d misses=%0d",
                 read_cnt_q, write_cnt_q, hit_cnt_q, miss_cnt_q);
    end
  end
`endif

endmodule

// File: tb/tb_cache_sim_core.sv
// Scoreboard bench for cache_sim_core: a reference cache model predicts each response,
// which is queued at drive time and compared when the registered result appears.
module tb_cache_sim_core;

  logic        clk, rst_n, cmd_valid;
  logic [3:0]  cmd;
  logic [31:0] read_address;
  logic [17:0] tag;
  logic [7:0]  index;
  logic [5:0]  byte_select;
  logic        cmd_done, hit_flag;
  logic [31:0] cache_read, cache_write, cache_hit, cache_miss;

  cache_sim_core dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd          (cmd),
    .read_address (read_address),
    .tag          (tag),
    .index        (index),
    .byte_select  (byte_select),
    .cmd_done     (cmd_done),
    .hit_flag     (hit_flag),
    .cache_read   (cache_read),
    .cache_write  (cache_write),
    .cache_hit    (cache_hit),
    .cache_miss   (cache_miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        chk_hit;
    bit        hit;
    bit [31:0] r, w, h, m;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  bit        mvalid [256][4];
  bit [17:0] mtag   [256][4];
  int        mage   [256][4];
  bit [31:0] mr, mw, mh, mm;

  function automatic void model_reset();
    for (int s = 0; s < 256; s++)
      for (int w = 0; w < 4; w++) begin
        mvalid[s][w] = 1'b0;
        mage[s][w]   = w;
      end
    mr = 0; mw = 0; mh = 0; mm = 0;
  endfunction

  function automatic void model_touch(int s, int k);
    int ak;
    ak = mage[s][k];
    for (int w = 0; w < 4; w++)
      if (w != k && mage[s][w] < ak) mage[s][w] = mage[s][w] + 1;
    mage[s][k] = 0;
  endfunction

  function automatic void model_apply(bit [3:0] c, bit [31:0] a);
    int        s, hw, v;
    bit [17:0] t;
    exp_t      e;
    s  = int'(a[13:6]);
    t  = a[31:14];
    hw = -1;
    v  = -1;
    for (int w = 0; w < 4; w++)
      if (mvalid[s][w] && mtag[s][w] == t) hw = w;
    e.chk_hit = 1'b0;
    e.hit     = 1'b0;
    case (c)
      4'd0, 4'd1, 4'd2: begin
        if (c == 4'd1) mw++; else mr++;
        if (hw >= 0) begin
          mh++;
          model_touch(s, hw);
        end else begin
          mm++;
          for (int w = 3; w >= 0; w--) if (!mvalid[s][w]) v = w;
          if (v < 0) for (int w = 0; w < 4; w++) if (mage[s][w] == 3) v = w;
          mvalid[s][v] = 1'b1;
          mtag[s][v]   = t;
          model_touch(s, v);
        end
        e.chk_hit = 1'b1;
        e.hit     = (hw >= 0);
      end
      4'd3: begin
        if (hw >= 0) mvalid[s][hw] = 1'b0;
        e.chk_hit = 1'b1;
        e.hit     = (hw >= 0);
      end
      4'd8: model_reset();
      4'd9: ;
      default: return;
    endcase
    e.r = mr; e.w = mw; e.h = mh; e.m = mm;
    sb.push_back(e);
  endfunction

  // Drive one command for one cycle and compare the registered response against the scoreboard.
  task automatic do_cmd(input bit [3:0] c, input bit [31:0] a);
    exp_t e;
    @(negedge clk);
    cmd_valid    = 1'b1;
    cmd          = c;
    read_address = a;
    #1;
    n_cmp++;
    if (tag !== a[31:14] || index !== a[13:6] || byte_select !== a[5:0]) begin
      n_bad++;
      $display("FAIL addr_split: addr=%h got tag=%h idx=%h off=%h", a, tag, index, byte_select);
    end
    model_apply(c, a);
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (cmd_done !== 1'b1) begin
        n_bad++;
        $display("FAIL cmd_done_pulse: cmd=%0d got %b want 1", c, cmd_done);
      end
      if (e.chk_hit) begin
        n_cmp++;
        if (hit_flag !== e.hit) begin
          n_bad++;
          $display("FAIL hit_flag: cmd=%0d addr=%h got %b want %b", c, a, hit_flag, e.hit);
        end
      end
      n_cmp++;
      if ({cache_read, cache_write, cache_hit, cache_miss} !== {e.r, e.w, e.h, e.m}) begin
        n_bad++;
        $display("FAIL counters: cmd=%0d got r=%0d w=%0d h=%0d m=%0d want r=%0d w=%0d h=%0d m=%0d",
                 c, cache_read, cache_write, cache_hit, cache_miss, e.r, e.w, e.h, e.m);
      end
    end else begin
      n_cmp++;
      if (cmd_done !== 1'b0) begin
        n_bad++;
        $display("FAIL cmd_done_ignored: cmd=%0d got %b want 0", c, cmd_done);
      end
      n_cmp++;
      if ({cache_read, cache_write, cache_hit, cache_miss} !== {mr, mw, mh, mm}) begin
        n_bad++;
        $display("FAIL counters_ignored: cmd=%0d got r=%0d w=%0d h=%0d m=%0d want r=%0d w=%0d h=%0d m=%0d",
                 c, cache_read, cache_write, cache_hit, cache_miss, mr, mw, mh, mm);
      end
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (cmd_done !== 1'b0 || {cache_read, cache_write, cache_hit, cache_miss} !== {mr, mw, mh, mm}) begin
      n_bad++;
      $display("FAIL idle: got done=%b r=%0d w=%0d h=%0d m=%0d want done=0 r=%0d w=%0d h=%0d m=%0d",
               cmd_done, cache_read, cache_write, cache_hit, cache_miss, mr, mw, mh, mm);
    end
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({cache_read, cache_write, cache_hit, cache_miss} !== 128'd0 || cmd_done !== 1'b0 || hit_flag !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got r=%0d w=%0d h=%0d m=%0d done=%b hit=%b want all 0",
               cache_read, cache_write, cache_hit, cache_miss, cmd_done, hit_flag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();
  endtask

  task automatic test_split_and_hit();
    do_cmd(4'd8, 32'h0);
    do_cmd(4'd0, 32'h0000_1040);
    n_cmp++;
    if (index !== 8'h41 || tag !== 18'h0 || byte_select !== 6'h0 || hit_flag !== 1'b0) begin
      n_bad++;
      $display("FAIL split_first: got idx=%h tag=%h off=%h hit=%b want idx=41 tag=0 off=0 hit=0",
               index, tag, byte_select, hit_flag);
    end
    do_cmd(4'd0, 32'h0000_1040);
    n_cmp++;
    if ({cache_read, cache_hit, cache_miss} !== {32'd2, 32'd1, 32'd1} || hit_flag !== 1'b1) begin
      n_bad++;
      $display("FAIL split_second: got r=%0d h=%0d m=%0d hit=%b want r=2 h=1 m=1 hit=1",
               cache_read, cache_hit, cache_miss, hit_flag);
    end
  endtask

  task automatic test_lru();
    bit [31:0] addrs [5];
    addrs = '{32'h1040, 32'h5040, 32'h9040, 32'hD040, 32'h11040};
    do_cmd(4'd8, 32'h0);
    foreach (addrs[i]) do_cmd(4'd0, addrs[i]);
    n_cmp++;
    if ({cache_read, cache_hit, cache_miss} !== {32'd5, 32'd0, 32'd5}) begin
      n_bad++;
      $display("FAIL lru_fill: got r=%0d h=%0d m=%0d want r=5 h=0 m=5", cache_read, cache_hit, cache_miss);
    end
    do_cmd(4'd0, 32'h1040);
    n_cmp++;
    if (hit_flag !== 1'b0) begin
      n_bad++;
      $display("FAIL lru_evicted: got hit=%b want 0", hit_flag);
    end
    do_cmd(4'd0, 32'h9040);
    n_cmp++;
    if (hit_flag !== 1'b1 || {cache_read, cache_hit, cache_miss} !== {32'd7, 32'd1, 32'd6}) begin
      n_bad++;
      $display("FAIL lru_survivor: got hit=%b r=%0d h=%0d m=%0d want hit=1 r=7 h=1 m=6",
               hit_flag, cache_read, cache_hit, cache_miss);
    end
  endtask

  task automatic test_write_alloc();
    do_cmd(4'd8, 32'h0);
    do_cmd(4'd1, 32'h2000);
    do_cmd(4'd0, 32'h2000);
    n_cmp++;
    if ({cache_read, cache_write, cache_hit, cache_miss} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
      n_bad++;
      $display("FAIL write_alloc: got r=%0d w=%0d h=%0d m=%0d want 1 1 1 1",
               cache_read, cache_write, cache_hit, cache_miss);
    end
  endtask

  task automatic test_invalidate();
    do_cmd(4'd8, 32'h0);
    do_cmd(4'd0, 32'h3000);
    do_cmd(4'd3, 32'h3000);
    n_cmp++;
    if (hit_flag !== 1'b1) begin
      n_bad++;
      $display("FAIL inval_match: got hit=%b want 1", hit_flag);
    end
    do_cmd(4'd0, 32'h3000);
    n_cmp++;
    if ({cache_read, cache_write, cache_hit, cache_miss} !== {32'd2, 32'd0, 32'd0, 32'd2}) begin
      n_bad++;
      $display("FAIL inval_counts: got r=%0d w=%0d h=%0d m=%0d want r=2 w=0 h=0 m=2",
               cache_read, cache_write, cache_hit, cache_miss);
    end
  endtask

  task automatic test_clear();
    do_cmd(4'd8, 32'h0);
    do_cmd(4'd0, 32'h4000);
    do_cmd(4'd1, 32'h4040);
    do_cmd(4'd0, 32'h4000);
    do_cmd(4'd2, 32'h8000);
    do_cmd(4'd1, 32'h4040);
    do_cmd(4'd0, 32'hC000);
    do_cmd(4'd8, 32'h0);
    n_cmp++;
    if ({cache_read, cache_write, cache_hit, cache_miss} !== 128'd0) begin
      n_bad++;
      $display("FAIL clear_counts: got r=%0d w=%0d h=%0d m=%0d want all 0",
               cache_read, cache_write, cache_hit, cache_miss);
    end
    do_cmd(4'd0, 32'h4000);
    n_cmp++;
    if ({cache_read, cache_hit, cache_miss} !== {32'd1, 32'd0, 32'd1}) begin
      n_bad++;
      $display("FAIL clear_refill: got r=%0d h=%0d m=%0d want r=1 h=0 m=1", cache_read, cache_hit, cache_miss);
    end
  endtask

  task automatic test_print_ignore();
    do_cmd(4'd9, 32'h4000);
    n_cmp++;
    if (cmd_done !== 1'b1) begin
      n_bad++;
      $display("FAIL print_done: got %b want 1", cmd_done);
    end
    do_cmd(4'd5, 32'h4000);
    n_cmp++;
    if (cmd_done !== 1'b0 || {cache_read, cache_write, cache_hit, cache_miss} !== {32'd1, 32'd0, 32'd0, 32'd1}) begin
      n_bad++;
      $display("FAIL ignore_cmd: got done=%b r=%0d w=%0d h=%0d m=%0d want done=0 r=1 w=0 h=0 m=1",
               cmd_done, cache_read, cache_write, cache_hit, cache_miss);
    end
  endtask

  task automatic test_back_to_back();
    int        r;
    bit [31:0] a;
    do_cmd(4'd8, 32'h0);
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      a = (32'($urandom_range(0, 5)) << 14) | (32'($urandom_range(0, 3)) << 6) | 32'($urandom_range(0, 63));
      if      (r < 35) do_cmd(4'd0, a);
      else if (r < 55) do_cmd(4'd1, a);
      else if (r < 68) do_cmd(4'd2, a);
      else if (r < 80) do_cmd(4'd3, a);
      else if (r < 85) do_cmd(4'd9, a);
      else if (r < 90) do_cmd(4'(10 + $urandom_range(0, 5)), a);
      else if (r < 92) do_cmd(4'd8, a);
      else             idle_cycle();
    end
  endtask

  task automatic test_async_reset();
    do_cmd(4'd0, 32'h1040);
    do_cmd(4'd1, 32'h5040);
    @(negedge clk);
    #2;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    #1;
    n_cmp++;
    if ({cache_read, cache_write, cache_hit, cache_miss} !== 128'd0 || cmd_done !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got r=%0d w=%0d h=%0d m=%0d done=%b want all 0",
               cache_read, cache_write, cache_hit, cache_miss, cmd_done);
    end
    model_reset();
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    do_cmd(4'd0, 32'h1040);
    n_cmp++;
    if (hit_flag !== 1'b0 || {cache_read, cache_miss} !== {32'd1, 32'd1}) begin
      n_bad++;
      $display("FAIL reset_refill: got hit=%b r=%0d m=%0d want hit=0 r=1 m=1", hit_flag, cache_read, cache_miss);
    end
  endtask

  initial begin
    clk          = 1'b0;
    rst_n        = 1'b0;
    cmd_valid    = 1'b0;
    cmd          = 4'd0;
    read_address = 32'h0;
    model_reset();
    test_reset();
    test_split_and_hit();
    test_lru();
    test_write_alloc();
    test_invalidate();
    test_clear();
    test_print_ignore();
    test_back_to_back();
    test_async_reset();
    idle_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
